exu_mc: RTL and testbench

Multi-cycle, parametrised execution unit for the npc core. It replaces the fixed single-cycle register-file-plus-ALU path with valid/ready handshakes on both sides, selectable immediate or register second operand, and iterative shifts. It also provides an optional iterative multiplier. The unit owns the architectural register file, sits between IDU (upstream) and WBU/commit logic (downstream), and writes back on output handshake.

---
 rtl/exu_mc.sv | 205 ++++++++++++++++++++
 tb/tb_exu_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_mc.sv
// exu_mc: multi-cycle execution unit owning the architectural register file.
// Latency: 1 cycle for ALU/reserved ops, 1+shamt for shifts, 1+XLEN for MUL (EXU_MC_MUL_EN).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or when DONE drains.
//
// Ports: clk/rst (sync, active-high); in_* request (valid/ready); out_* result (valid/ready);
//        dbg_raddr/dbg_rdata combinational register-file peek.
// Optional feature: define EXU_MC_MUL_EN to build the iterative shift-add multiplier (op 10).
module exu_mc #(
    parameter int XLEN    = 32,
    parameter int NR_REGS = 32,
    parameter int REG_AW  = $clog2(NR_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wen,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [XLEN-1:0]   dbg_rdata
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef EXU_MC_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef EXU_MC_MUL_EN
        S_MUL   = 2'd3,
`endif
        S_DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt, start_state;
    logic [XLEN-1:0]   rf [NR_REGS];
    logic [XLEN-1:0]   acc;      // result / shift value / partial product
    logic [CW-1:0]     cnt;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic              wen_q;
`ifdef EXU_MC_MUL_EN
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
`endif

    logic              accept, wb_fire, is_shift, is_mul;
    logic [XLEN-1:0]   rs1_val, rs2_val, src1, src2, alu_res, shifted;
    logic [SHW-1:0]    shamt;

    assign in_ready   = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == S_DONE);
    assign out_result = acc;
    assign out_rd     = rd_q;
    assign out_wen    = wen_q;
    assign wb_fire    = out_valid && out_ready && wen_q && (rd_q != '0);

    // Forward the value being written back this cycle so a dependent op issued
    // on the same edge sees it without a stall.
    assign rs1_val = (wb_fire && rd_q == in_rs1) ? acc : rf[in_rs1];
    assign rs2_val = (wb_fire && rd_q == in_rs2) ? acc : rf[in_rs2];
    assign src1    = rs1_val;
    assign src2    = in_use_imm ? in_imm : rs2_val;
    assign shamt   = src2[SHW-1:0];
    assign is_shift = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
`ifdef EXU_MC_MUL_EN
    assign is_mul  = (in_op == OP_MUL);
`else
    assign is_mul  = 1'b0;
`endif

    assign dbg_rdata = (dbg_raddr == '0) ? '0 : rf[dbg_raddr];

    always_comb begin
        alu_res = '0;
        case (in_op)
            OP_ADD:  alu_res = src1 + src2;
            OP_SUB:  alu_res = src1 - src2;
            OP_AND:  alu_res = src1 & src2;
            OP_OR:   alu_res = src1 | src2;
            OP_XOR:  alu_res = src1 ^ src2;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
            default: alu_res = '0;
        endcase
    end

    // One-bit step of the in-flight shift; direction comes from the latched op.
    always_comb begin
        shifted = acc;
        case (op_q)
            OP_SLL:  shifted = {acc[XLEN-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, acc[XLEN-1:1]};
            OP_SRA:  shifted = {acc[XLEN-1], acc[XLEN-1:1]};
            default: shifted = acc;
        endcase
    end

    always_comb begin
        start_state = S_DONE;
        if (is_shift && shamt != '0) begin
            start_state = S_SHIFT;
        end
`ifdef EXU_MC_MUL_EN
        if (is_mul) begin
            start_state = S_MUL;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = start_state;
            S_SHIFT: if (cnt == CW'(1)) state_nxt = S_DONE;
`ifdef EXU_MC_MUL_EN
            S_MUL:   if (cnt == CW'(1)) state_nxt = S_DONE;
`endif
            S_DONE:  if (out_ready) state_nxt = accept ? start_state : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            op_q  <= '0;
            rd_q  <= '0;
            wen_q <= 1'b0;
`ifdef EXU_MC_MUL_EN
            mcand  <= '0;
            mplier <= '0;
`endif
            for (int i = 0; i < NR_REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (wb_fire) begin
                rf[rd_q] <= acc;
            end
            if (accept) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                wen_q <= in_wen;
                cnt   <= {1'b0, shamt};
                acc   <= is_shift ? src1 : alu_res;
`ifdef EXU_MC_MUL_EN
                if (is_mul) begin
                    acc    <= '0;
                    mcand  <= src1;
                    mplier <= src2;
                    cnt    <= CW'(XLEN);
                end
`endif
            end
            if (state == S_SHIFT) begin
                acc <= shifted;
                cnt <= cnt - CW'(1);
            end
`ifdef EXU_MC_MUL_EN
            if (state == S_MUL) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= {mcand[XLEN-2:0], 1'b0};
                mplier <= {1'b0, mplier[XLEN-1:1]};
                cnt    <= cnt - CW'(1);
            end
`endif
        end
    end
endmodule

// File: tb/tb_exu_mc.sv
// tb_exu_mc: directed stimulus for exu_mc with a queue-based scoreboard.
// Expected results and first-valid cycles are pushed at accept; a monitor pops on handshake.
// Stalled outputs are checked for stability and in_ready low.
module tb_exu_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm;
    logic        in_use_imm, in_wen;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exu_mc dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wen(out_wen),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, after the driver has settled its inputs.
    initial begin : monitor
        bit   waiting = 0;
        int   start = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                waiting = 0;
            end else if (out_valid) begin
                if (!waiting) begin
                    waiting = 1;
                    start = cyc;
                end
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                    if (out_ready) waiting = 0;
                end else begin
                    e = q[0];
                    if (out_ready) begin
                        void'(q.pop_front());
                        chk("result", out_result, e.res);
                        chk("rd", 32'(out_rd), 32'(e.rd));
                        chk("wen", 32'(out_wen), 32'(e.wen));
                        chk("first_valid_cycle", 32'(start), 32'(e.cyc));
                        waiting = 0;
                    end else begin
                        chk("stall_result", out_result, e.res);
                        chk("stall_rd", 32'(out_rd), 32'(e.rd));
                        chk("stall_wen", 32'(out_wen), 32'(e.wen));
                        chk("stall_in_ready", 32'(in_ready), 32'd0);
                    end
                end
            end
        end
    end

    // Issue one request; the accept cycle T is the cycle in which in_valid&&in_ready holds.
    task automatic issue(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic use_imm,
                         input logic wen, input logic [31:0] exp_res, input int lat);
        exp_t e;
        bit   ok = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_imm = imm; in_use_imm = use_imm; in_wen = wen;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.res = exp_res; e.rd = rd; e.wen = wen; e.cyc = cyc + lat;
            q.push_back(e);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic chk_reg(input logic [4:0] a, input logic [31:0] exp);
        @(negedge clk);
        dbg_raddr = a;
        #1 chk($sformatf("dbg_R%0d", a), dbg_rdata, exp);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_imm = '0; in_use_imm = 1'b0; in_wen = 1'b0; out_ready = 1'b1; dbg_raddr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_out_rd", 32'(out_rd), 32'd0);
        chk("reset_out_wen", 32'(out_wen), 32'd0);
        chk_reg(5'd1, 32'd0);

        // ADD imm, then back-to-back dependent ops relying on writeback bypass
        issue(4'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 1'b1, 32'd5, 1);
        issue(4'd0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'd10, 1);
        issue(4'd0, 5'd2, 5'd0, 5'd3, 32'd1, 1'b1, 1'b1, 32'd11, 1);
        drain();
        chk_reg(5'd1, 32'd5);
        chk_reg(5'd2, 32'd10);
        chk_reg(5'd3, 32'd11);

        // Shifts
        issue(4'd0, 5'd0, 5'd0, 5'd4, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0000, 1);
        issue(4'd9, 5'd4, 5'd0, 5'd5, 32'd4, 1'b1, 1'b1, 32'hF800_0000, 5);
        issue(4'd7, 5'd3, 5'd0, 5'd6, 32'd0, 1'b1, 1'b1, 32'd11, 1);
        issue(4'd8, 5'd4, 5'd0, 5'd7, 32'd31, 1'b1, 1'b1, 32'd1, 32);
        issue(4'd7, 5'd1, 5'd3, 5'd8, 32'd0, 1'b0, 1'b1, 32'h0000_2800, 12);
        drain();
        chk_reg(5'd5, 32'hF800_0000);

        // Backpressure: 3 stalled cycles, no write until the handshake
        out_ready = 1'b0;
        issue(4'd0, 5'd1, 5'd0, 5'd1, 32'd2, 1'b1, 1'b1, 32'd7, 1);
        chk_reg(5'd1, 32'd5);
        repeat (2) @(negedge clk);
        chk_reg(5'd1, 32'd5);
        out_ready = 1'b1;
        drain();
        chk_reg(5'd1, 32'd7);

        // x0 write, SUB wrap, compares, logic ops, reserved, wen=0
        issue(4'd0, 5'd0, 5'd0, 5'd0, 32'd7, 1'b1, 1'b1, 32'd7, 1);
        issue(4'd1, 5'd0, 5'd0, 5'd9, 32'd1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1);
        issue(4'd5, 5'd9, 5'd0, 5'd10, 32'd1, 1'b1, 1'b1, 32'd1, 1);
        issue(4'd6, 5'd9, 5'd0, 5'd11, 32'd1, 1'b1, 1'b1, 32'd0, 1);
        issue(4'd2, 5'd9, 5'd0, 5'd14, 32'hF0, 1'b1, 1'b1, 32'hF0, 1);
        issue(4'd3, 5'd1, 5'd0, 5'd15, 32'h100, 1'b1, 1'b1, 32'h107, 1);
        issue(4'd4, 5'd9, 5'd0, 5'd16, 32'h0F, 1'b1, 1'b1, 32'hFFFF_FFF0, 1);
        issue(4'd12, 5'd9, 5'd1, 5'd17, 32'd3, 1'b1, 1'b1, 32'd0, 1);
        issue(4'd0, 5'd0, 5'd0, 5'd12, 32'd9, 1'b1, 1'b0, 32'd9, 1);
        drain();
        chk_reg(5'd0, 32'd0);
        chk_reg(5'd10, 32'd1);
        chk_reg(5'd12, 32'd0);

        // Multiplier (or reserved op 10)
`ifdef EXU_MC_MUL_EN
        issue(4'd10, 5'd9, 5'd0, 5'd13, 32'd3, 1'b1, 1'b1, 32'hFFFF_FFFD, 33);
`else
        issue(4'd10, 5'd9, 5'd0, 5'd13, 32'd3, 1'b1, 1'b1, 32'd0, 1);
`endif
        drain();

        // Reset 10 cycles into a long op: abandoned, register file cleared
`ifdef EXU_MC_MUL_EN
        issue(4'd10, 5'd9, 5'd0, 5'd18, 32'd3, 1'b1, 1'b1, 32'hFFFF_FFFD, 33);
`else
        issue(4'd8, 5'd4, 5'd0, 5'd18, 32'd31, 1'b1, 1'b1, 32'd1, 32);
`endif
        repeat (9) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk_reg(5'd1, 32'd0);
        chk_reg(5'd9, 32'd0);
        chk_reg(5'd18, 32'd0);
        repeat (40) @(negedge clk);
        chk("rst_no_late_out", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
